// File: rtl/ula_ctrl_if.sv
// ula_ctrl_if: instruction handshake bundle between an instruction source and ula_ctrl
//   instr[7:0]  {op[7:4], ra[3:2], rb[1:0]}      imm  immediate for LI
//   instr_valid instruction offered              instr_ready  sequencer can accept
//   done        one-cycle pulse on completion of writeback or NOP
interface ula_ctrl_if #(parameter int DATA_W = 8);
   logic [7:0]        instr;
   logic [DATA_W-1:0] imm;
   logic              instr_valid;
   logic              instr_ready;
   logic              done;
   modport master (output instr, imm, instr_valid, input instr_ready, done);
   modport slave  (input instr, imm, instr_valid, output instr_ready, done);
endinterface

// File: rtl/ula_ctrl.sv
// ula_ctrl: operand/writeback sequencer for the combinational 8-bit ULA with a 4-entry register bank
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         instruction handshake: instr, imm, instr_valid, instr_ready, done
//   alu_a/alu_b/alu_sel registered operands and selector to the ULA
//   alu_s/alu_zero      ULA result and zero flag
//   zero_flag           sticky ZERO of the last ALU op
//   dbg_idx/dbg_data    combinational register bank read
//   perf_cnt            done-pulse counter, present only with ULA_CTRL_PERF_CNT_EN
module ula_ctrl #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   ula_ctrl_if.slave         bus,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [SEL_W-1:0]  alu_sel,
   input  logic [DATA_W-1:0] alu_s,
   input  logic              alu_zero,
   output logic              zero_flag,
   input  logic [1:0]        dbg_idx,
   output logic [DATA_W-1:0] dbg_data
`ifdef ULA_CTRL_PERF_CNT_EN
   ,
   output logic [15:0]       perf_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
   state_t state, next;
   logic [7:0]        ins_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] r [4];
   logic [3:0] op;
   logic [1:0] ra, rb;
   logic is_alu, is_li;
   assign op     = ins_q[7:4];
   assign ra     = ins_q[3:2];
   assign rb     = ins_q[1:0];
   assign is_alu = op <= 4'd9;
   assign is_li  = op == 4'hA;
   assign bus.instr_ready = state == IDLE;
   assign bus.done        = state == WB;
   assign dbg_data = r[dbg_idx];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= next;
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = bus.instr_valid ? READ : IDLE;
         READ:    next = EXEC;
         EXEC:    next = WB;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ins_q     <= '0;
         imm_q     <= '0;
         result    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         zero_flag <= 1'b0;
         r         <= '{default: '0};
      end else begin
         if (state == IDLE && bus.instr_valid) begin
            ins_q <= bus.instr;
            imm_q <= bus.imm;
         end
         // operands are read here, before any writeback, so ra == rb is safe
         if (state == READ) begin
            alu_a <= r[ra];
            alu_b <= r[rb];
            if (is_alu) alu_sel <= SEL_W'(op);
         end
         if (state == EXEC && (is_alu || is_li)) result <= is_alu ? alu_s : imm_q;
         if (state == EXEC && is_alu) zero_flag <= alu_zero;
         if (state == WB && (is_alu || is_li)) r[ra] <= result;
      end
`ifdef ULA_CTRL_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)           perf_cnt <= '0;
      else if (state == WB) perf_cnt <= perf_cnt + 16'd1;
`endif
endmodule
